alu_fu: RTL and testbench
=========================

Name: alu_fu

Overview:
- Two-stage pipelined integer ALU functional unit; consumes FU_ALU scoreboard entries issued after decode, with operands already resolved.
- Executes OP/OPIMM/OP32/OPIMM32/AUIPC arithmetic, resolves BRANCH and JALR, and returns result plus branch-resolution info to writeback/scoreboard.
- Uses a valid/ready handshake on both sides and supports a flush that discards in-flight work.

Parameters:
- XLEN, 64, data/address width.
- TRANS_ID_W, 3, scoreboard transaction-id width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- flush_i  in  1  discard all in-flight entries
- in_valid_i  in  1  issue request
- in_ready_o  out  1  unit can accept this cycle
- in_op_i  in  alu op enum (tortoise_pkg)  operation: ADD SUB SLL SRL SRA XORL ORL ANDL CMP_LTS CMP_LTU CMP_EQ CMP_NE CMP_GES CMP_GEU ADDW SUBW SLLW SRLW SRAW JAL_R
- in_op1_i, in_op2_i  in  XLEN  resolved operands
- in_op3_i  in  XLEN  link value (pc+4); JAL_R only
- in_is_branch_i  in  1  entry is a conditional branch
- in_pred_taken_i  in  1  fetch prediction taken
- in_pred_target_i  in  XLEN  fetch-predicted target
- in_next_pc_i  in  XLEN  fall-through pc
- in_trans_id_i  in  TRANS_ID_W  scoreboard slot
- out_valid_o  out  1  result available
- out_ready_i  in  1  consumer accepts
- out_result_o  out  XLEN  rd write value
- out_trans_id_o  out  TRANS_ID_W  slot of result
- out_mispredict_o  out  1  redirect needed
- out_redirect_pc_o  out  XLEN  correct next pc

Behaviour:
- Reset: both stage valids 0; out_valid_o=0, in_ready_o=1, all data outputs 0.
- Handshake: transfer on valid&ready. S1 (operand register) loads on input transfer. S2 (output register) loads from S1 when S2 is empty or out_ready_i=1. in_ready_o = !s1_valid | s2_advance (combinational, no dependency on in_valid_i). Latency 2 cycles from accept to out_valid_o; throughput 1/cycle; full backpressure holds both stages without loss or duplication.
- out_* stable while out_valid_o=1 and out_ready_i=0.
- Compute happens in S1 combinationally; S2 registers results.
- ADD/SUB/logic: full XLEN, wrap modulo 2^XLEN. SLL/SRL/SRA use op2[5:0].
- W ops: 32-bit operation on op1[31:0], op2[31:0]; shift amount op2[4:0]; result sign-extended from bit 31.
- CMP_*: result 0 or 1, zero-extended; LTS/GES signed, LTU/GEU unsigned.
- Conditional branch (in_is_branch_i=1): taken = compare result; out_result_o=0; redirect_pc = taken ? pred_target : next_pc; mispredict = taken != pred_taken.
- JAL_R: target = (op1+op2) with bit 0 cleared; out_result_o = op3; redirect_pc = target; mispredict = !pred_taken | (pred_target != target).
- Non-branch, non-JAL_R: mispredict=0, redirect_pc=next_pc.
- flush_i: next cycle s1_valid=s2_valid=0; any input offered in the flush cycle is dropped. Flush dominates simultaneous accept and advance.
- Reset mid-operation: identical to flush, plus data registers cleared.

Test Plan:
- ADD op1=0xFFFF_FFFF_FFFF_FFFF, op2=1, out_ready=1 -> out_valid 2 cycles later, result=0, trans_id echoed.
- ADDW op1=0x7FFF_FFFF, op2=1 -> result=0xFFFF_FFFF_8000_0000. SRAW op1=0x8000_0000, op2=4 -> 0xFFFF_FFFF_F800_0000. SRA op1=0x8000_0000_0000_0000, op2=63 -> all ones.
- Branch CMP_LTS op1=-1, op2=0, pred_taken=0, pred_target=0x1000, next_pc=0x804 -> mispredict=1, redirect=0x1000. Same with CMP_LTU -> not taken, mispredict=0, redirect=0x804.
- JAL_R op1=0x2001, op2=0x10, op3=0x404, pred_taken=1, pred_target=0x2010 -> result=0x404, redirect=0x2010, mispredict=0; pred_target=0x2011 -> mispredict=1.
- Back-to-back 4 issues with out_ready low 3 cycles -> in_ready drops after 2 accepted; all 4 results emerge in order, none lost or duplicated.
- flush_i asserted with both stages full and new issue offered -> next cycle out_valid=0, in_ready=1; no result from the flushed entries ever appears.

Source files
------------

// File: rtl/alu_fu.sv
`default_nettype none

//==============================================================================
// Package : tortoise_pkg
// Purpose : ALU operation encoding shared by the ALU functional unit and its
//           issue logic.
// Revision: 1.0 - initial release
//==============================================================================
package tortoise_pkg;

    typedef enum logic [4:0] {
        ADD     = 5'd0,
        SUB     = 5'd1,
        SLL     = 5'd2,
        SRL     = 5'd3,
        SRA     = 5'd4,
        XORL    = 5'd5,
        ORL     = 5'd6,
        ANDL    = 5'd7,
        CMP_LTS = 5'd8,
        CMP_LTU = 5'd9,
        CMP_EQ  = 5'd10,
        CMP_NE  = 5'd11,
        CMP_GES = 5'd12,
        CMP_GEU = 5'd13,
        ADDW    = 5'd14,
        SUBW    = 5'd15,
        SLLW    = 5'd16,
        SRLW    = 5'd17,
        SRAW    = 5'd18,
        JAL_R   = 5'd19
    } alu_op_t;

endpackage

//==============================================================================
// Module  : alu_fu
// Purpose : Two-stage pipelined integer ALU functional unit. S1 registers the
//           issued operands and computes combinationally; S2 registers the
//           result and the branch/JALR resolution for writeback.
// Ports   :
//   clk_i, rst_i              clock, synchronous active-high reset
//   flush_i                   drop every in-flight entry
//   in_valid_i / in_ready_o   issue handshake
//   in_op_i, in_op1..3_i      operation and resolved operands (op3 = link)
//   in_is_branch_i            conditional branch entry
//   in_pred_taken_i/target_i  fetch prediction
//   in_next_pc_i              fall-through pc
//   in_trans_id_i             scoreboard slot
//   out_valid_o / out_ready_i result handshake
//   out_result_o              rd write value
//   out_trans_id_o            slot of the result
//   out_mispredict_o          redirect required
//   out_redirect_pc_o         correct next pc
// Revision: 1.0 - initial release
//==============================================================================
module alu_fu
    import tortoise_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int TRANS_ID_W = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  alu_op_t               in_op_i,
    input  logic [XLEN-1:0]       in_op1_i,
    input  logic [XLEN-1:0]       in_op2_i,
    input  logic [XLEN-1:0]       in_op3_i,
    input  logic                  in_is_branch_i,
    input  logic                  in_pred_taken_i,
    input  logic [XLEN-1:0]       in_pred_target_i,
    input  logic [XLEN-1:0]       in_next_pc_i,
    input  logic [TRANS_ID_W-1:0] in_trans_id_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [XLEN-1:0]       out_result_o,
    output logic [TRANS_ID_W-1:0] out_trans_id_o,
    output logic                  out_mispredict_o,
    output logic [XLEN-1:0]       out_redirect_pc_o
);

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    logic                  r_s1_valid;
    alu_op_t               r_s1_op;
    logic [XLEN-1:0]       r_s1_op1;
    logic [XLEN-1:0]       r_s1_op2;
    logic [XLEN-1:0]       r_s1_op3;
    logic                  r_s1_is_branch;
    logic                  r_s1_pred_taken;
    logic [XLEN-1:0]       r_s1_pred_target;
    logic [XLEN-1:0]       r_s1_next_pc;
    logic [TRANS_ID_W-1:0] r_s1_trans_id;

    logic                  r_s2_valid;
    logic [XLEN-1:0]       r_s2_result;
    logic [TRANS_ID_W-1:0] r_s2_trans_id;
    logic                  r_s2_mispredict;
    logic [XLEN-1:0]       r_s2_redirect_pc;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic w_s2_load_en;
    logic w_s2_advance;
    logic w_in_fire;

    // S2 can take a new entry when it is empty or being drained this cycle.
    assign w_s2_load_en = !r_s2_valid || out_ready_i;
    // !s1_valid | (s1_valid & load_en) reduces to !s1_valid | load_en.
    assign in_ready_o   = !r_s1_valid || w_s2_load_en;
    // Flush wins over both transfers so nothing from the flush cycle survives.
    assign w_in_fire    = in_valid_i && in_ready_o && !flush_i;
    assign w_s2_advance = r_s1_valid && w_s2_load_en && !flush_i;

    // ------------------------------------------------------------------
    // S1 compute
    // ------------------------------------------------------------------
    logic [5:0]      w_shamt;
    logic [4:0]      w_shamt_w;
    logic [XLEN-1:0] w_sum;
    logic [XLEN-1:0] w_diff;
    logic [XLEN-1:0] w_sra;
    logic [31:0]     w_sllw;
    logic [31:0]     w_srlw;
    logic [31:0]     w_sraw;
    logic            w_lts;
    logic            w_ltu;
    logic            w_eq;
    logic [XLEN-1:0] w_jalr_target;
    logic [XLEN-1:0] w_alu_result;
    logic            w_taken;
    logic [XLEN-1:0] w_result;
    logic            w_mispredict;
    logic [XLEN-1:0] w_redirect_pc;

    assign w_shamt   = r_s1_op2[5:0];
    assign w_shamt_w = r_s1_op2[4:0];
    assign w_sum     = r_s1_op1 + r_s1_op2;
    assign w_diff    = r_s1_op1 - r_s1_op2;
    assign w_sra     = $signed(r_s1_op1) >>> w_shamt;
    assign w_sllw    = r_s1_op1[31:0] << w_shamt_w;
    assign w_srlw    = r_s1_op1[31:0] >> w_shamt_w;
    assign w_sraw    = $signed(r_s1_op1[31:0]) >>> w_shamt_w;
    assign w_lts     = $signed(r_s1_op1) < $signed(r_s1_op2);
    assign w_ltu     = r_s1_op1 < r_s1_op2;
    assign w_eq      = r_s1_op1 == r_s1_op2;

    // JALR target: the adder output with bit 0 forced low.
    assign w_jalr_target = {w_sum[XLEN-1:1], 1'b0};

    // The low 32 bits of the full-width sum/difference are the W-op results,
    // so the W variants only need sign extension from bit 31.
    always_comb begin
        w_alu_result = '0;
        case (r_s1_op)
            ADD:     w_alu_result = w_sum;
            SUB:     w_alu_result = w_diff;
            SLL:     w_alu_result = r_s1_op1 << w_shamt;
            SRL:     w_alu_result = r_s1_op1 >> w_shamt;
            SRA:     w_alu_result = w_sra;
            XORL:    w_alu_result = r_s1_op1 ^ r_s1_op2;
            ORL:     w_alu_result = r_s1_op1 | r_s1_op2;
            ANDL:    w_alu_result = r_s1_op1 & r_s1_op2;
            CMP_LTS: w_alu_result = {{(XLEN-1){1'b0}}, w_lts};
            CMP_LTU: w_alu_result = {{(XLEN-1){1'b0}}, w_ltu};
            CMP_EQ:  w_alu_result = {{(XLEN-1){1'b0}}, w_eq};
            CMP_NE:  w_alu_result = {{(XLEN-1){1'b0}}, !w_eq};
            CMP_GES: w_alu_result = {{(XLEN-1){1'b0}}, !w_lts};
            CMP_GEU: w_alu_result = {{(XLEN-1){1'b0}}, !w_ltu};
            ADDW:    w_alu_result = {{(XLEN-32){w_sum[31]}}, w_sum[31:0]};
            SUBW:    w_alu_result = {{(XLEN-32){w_diff[31]}}, w_diff[31:0]};
            SLLW:    w_alu_result = {{(XLEN-32){w_sllw[31]}}, w_sllw};
            SRLW:    w_alu_result = {{(XLEN-32){w_srlw[31]}}, w_srlw};
            SRAW:    w_alu_result = {{(XLEN-32){w_sraw[31]}}, w_sraw};
            JAL_R:   w_alu_result = r_s1_op3;
            default: w_alu_result = '0;
        endcase
    end

    // Branches carry a compare op, whose result is exactly 0 or 1.
    assign w_taken = w_alu_result[0];

    always_comb begin
        w_result      = w_alu_result;
        w_mispredict  = 1'b0;
        w_redirect_pc = r_s1_next_pc;
        if (r_s1_is_branch) begin
            w_result      = '0;
            w_redirect_pc = w_taken ? r_s1_pred_target : r_s1_next_pc;
            w_mispredict  = w_taken != r_s1_pred_taken;
        end else if (r_s1_op == JAL_R) begin
            w_result      = r_s1_op3;
            w_redirect_pc = w_jalr_target;
            w_mispredict  = !r_s1_pred_taken || (r_s1_pred_target != w_jalr_target);
        end
    end

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1_valid       <= 1'b0;
            r_s1_op          <= ADD;
            r_s1_op1         <= '0;
            r_s1_op2         <= '0;
            r_s1_op3         <= '0;
            r_s1_is_branch   <= 1'b0;
            r_s1_pred_taken  <= 1'b0;
            r_s1_pred_target <= '0;
            r_s1_next_pc     <= '0;
            r_s1_trans_id    <= '0;
            r_s2_valid       <= 1'b0;
            r_s2_result      <= '0;
            r_s2_trans_id    <= '0;
            r_s2_mispredict  <= 1'b0;
            r_s2_redirect_pc <= '0;
        end else begin
            if (flush_i) begin
                r_s1_valid <= 1'b0;
                r_s2_valid <= 1'b0;
            end else begin
                if (in_ready_o) begin
                    r_s1_valid <= in_valid_i;
                end
                if (w_s2_load_en) begin
                    r_s2_valid <= r_s1_valid;
                end
            end

            if (w_in_fire) begin
                r_s1_op          <= in_op_i;
                r_s1_op1         <= in_op1_i;
                r_s1_op2         <= in_op2_i;
                r_s1_op3         <= in_op3_i;
                r_s1_is_branch   <= in_is_branch_i;
                r_s1_pred_taken  <= in_pred_taken_i;
                r_s1_pred_target <= in_pred_target_i;
                r_s1_next_pc     <= in_next_pc_i;
                r_s1_trans_id    <= in_trans_id_i;
            end

            if (w_s2_advance) begin
                r_s2_result      <= w_result;
                r_s2_trans_id    <= r_s1_trans_id;
                r_s2_mispredict  <= w_mispredict;
                r_s2_redirect_pc <= w_redirect_pc;
            end
        end
    end

    assign out_valid_o       = r_s2_valid;
    assign out_result_o      = r_s2_result;
    assign out_trans_id_o    = r_s2_trans_id;
    assign out_mispredict_o  = r_s2_mispredict;
    assign out_redirect_pc_o = r_s2_redirect_pc;

endmodule

`default_nettype wire

// File: tb/tb_alu_fu.sv
`default_nettype none

//==============================================================================
// Module  : tb_alu_fu
// Purpose : Self-checking bench for alu_fu: table of directed vectors plus
//           hand-written backpressure, flush and reset sequences.
// Revision: 1.0 - initial release
//==============================================================================
module tb_alu_fu;
    import tortoise_pkg::*;

    localparam int XLEN       = 64;
    localparam int TRANS_ID_W = 3;

    logic                  clk_i = 1'b0;
    logic                  rst_i;
    logic                  flush_i;
    logic                  in_valid_i;
    logic                  in_ready_o;
    alu_op_t               in_op_i;
    logic [XLEN-1:0]       in_op1_i;
    logic [XLEN-1:0]       in_op2_i;
    logic [XLEN-1:0]       in_op3_i;
    logic                  in_is_branch_i;
    logic                  in_pred_taken_i;
    logic [XLEN-1:0]       in_pred_target_i;
    logic [XLEN-1:0]       in_next_pc_i;
    logic [TRANS_ID_W-1:0] in_trans_id_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [XLEN-1:0]       out_result_o;
    logic [TRANS_ID_W-1:0] out_trans_id_o;
    logic                  out_mispredict_o;
    logic [XLEN-1:0]       out_redirect_pc_o;

    alu_fu #(.XLEN(XLEN), .TRANS_ID_W(TRANS_ID_W)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .flush_i           (flush_i),
        .in_valid_i        (in_valid_i),
        .in_ready_o        (in_ready_o),
        .in_op_i           (in_op_i),
        .in_op1_i          (in_op1_i),
        .in_op2_i          (in_op2_i),
        .in_op3_i          (in_op3_i),
        .in_is_branch_i    (in_is_branch_i),
        .in_pred_taken_i   (in_pred_taken_i),
        .in_pred_target_i  (in_pred_target_i),
        .in_next_pc_i      (in_next_pc_i),
        .in_trans_id_i     (in_trans_id_i),
        .out_valid_o       (out_valid_o),
        .out_ready_i       (out_ready_i),
        .out_result_o      (out_result_o),
        .out_trans_id_o    (out_trans_id_o),
        .out_mispredict_o  (out_mispredict_o),
        .out_redirect_pc_o (out_redirect_pc_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string      name;
        alu_op_t    op;
        logic [63:0] op1;
        logic [63:0] op2;
        logic [63:0] op3;
        logic        is_branch;
        logic        pred_taken;
        logic [63:0] pred_target;
        logic [63:0] next_pc;
        logic [63:0] exp_result;
        logic        exp_misp;
        logic [63:0] exp_redirect;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(input string n, input alu_op_t op,
                                input logic [63:0] a, input logic [63:0] b,
                                input logic [63:0] c, input logic br,
                                input logic pt, input logic [63:0] tgt,
                                input logic [63:0] npc, input logic [63:0] res,
                                input logic mp, input logic [63:0] rd);
        vec_t v;
        v.name = n; v.op = op; v.op1 = a; v.op2 = b; v.op3 = c;
        v.is_branch = br; v.pred_taken = pt; v.pred_target = tgt;
        v.next_pc = npc; v.exp_result = res; v.exp_misp = mp; v.exp_redirect = rd;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input logic [TRANS_ID_W-1:0] id);
        in_op_i          = v.op;
        in_op1_i         = v.op1;
        in_op2_i         = v.op2;
        in_op3_i         = v.op3;
        in_is_branch_i   = v.is_branch;
        in_pred_taken_i  = v.pred_taken;
        in_pred_target_i = v.pred_target;
        in_next_pc_i     = v.next_pc;
        in_trans_id_i    = id;
    endtask

    task automatic drive_add(input logic [63:0] a, input logic [63:0] b,
                             input logic [TRANS_ID_W-1:0] id);
        drive(mk("add", ADD, a, b, 64'd0, 1'b0, 1'b0, 64'd0, 64'h40, 64'd0, 1'b0, 64'd0), id);
    endtask

    // Issue one vector into an idle unit and check the full result record.
    task automatic run_vector(input vec_t v, input logic [TRANS_ID_W-1:0] id);
        int n;
        @(posedge clk_i); #1;
        drive(v, id);
        in_valid_i  = 1'b1;
        out_ready_i = 1'b1;
        n = 0;
        while (!in_ready_o && n < 10) begin
            @(posedge clk_i); #1; n++;
        end
        if (n >= 10) check({v.name, " accept_timeout"}, 64'd1, 64'd0);
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        n = 0;
        while (!out_valid_o && n < 10) begin
            @(posedge clk_i); #1; n++;
        end
        // Offered in cycle 0, valid in cycle 2: one more edge after the accept edge.
        check({v.name, " latency_edges"}, 64'(n), 64'd1);
        check({v.name, " result"}, out_result_o, v.exp_result);
        check({v.name, " trans_id"}, 64'(out_trans_id_o), 64'(id));
        check({v.name, " mispredict"}, 64'(out_mispredict_o), 64'(v.exp_misp));
        check({v.name, " redirect"}, out_redirect_pc_o, v.exp_redirect);
    endtask

    task automatic count_outputs(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk_i); #1;
            if (out_valid_o) cnt++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, rcv, stab_err, extra, k;
        logic seen_drop, stall_prev;
        logic [63:0] prev_res;
        logic [TRANS_ID_W-1:0] prev_id;

        // ---------------- directed vector table ----------------
        vecs.push_back(mk("add_wrap", ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, 0, 0, 64'h104, 64'd0, 0, 64'h104));
        vecs.push_back(mk("add_pred_ignored", ADD, 64'd5, 64'd7, 0, 0, 1, 64'hDEAD, 64'h108, 64'd12, 0, 64'h108));
        vecs.push_back(mk("sub_wrap", SUB, 64'd0, 64'd1, 0, 0, 0, 0, 64'h10C, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'h10C));
        vecs.push_back(mk("sll_mask", SLL, 64'd1, 64'h43, 0, 0, 0, 0, 64'h110, 64'd8, 0, 64'h110));
        vecs.push_back(mk("srl_63", SRL, 64'h8000_0000_0000_0000, 64'd63, 0, 0, 0, 0, 64'h114, 64'd1, 0, 64'h114));
        vecs.push_back(mk("sra_63", SRA, 64'h8000_0000_0000_0000, 64'd63, 0, 0, 0, 0, 64'h118, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'h118));
        vecs.push_back(mk("xor", XORL, 64'hF0F0, 64'hFF00, 0, 0, 0, 0, 64'h11C, 64'h0FF0, 0, 64'h11C));
        vecs.push_back(mk("or", ORL, 64'hF0, 64'h0F, 0, 0, 0, 0, 64'h120, 64'hFF, 0, 64'h120));
        vecs.push_back(mk("and", ANDL, 64'hF0F0, 64'hFF00, 0, 0, 0, 0, 64'h124, 64'hF000, 0, 64'h124));
        vecs.push_back(mk("addw_ovf", ADDW, 64'h7FFF_FFFF, 64'd1, 0, 0, 0, 0, 64'h128, 64'hFFFF_FFFF_8000_0000, 0, 64'h128));
        vecs.push_back(mk("subw", SUBW, 64'd0, 64'd1, 0, 0, 0, 0, 64'h12C, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'h12C));
        vecs.push_back(mk("sllw", SLLW, 64'd1, 64'd31, 0, 0, 0, 0, 64'h130, 64'hFFFF_FFFF_8000_0000, 0, 64'h130));
        vecs.push_back(mk("srlw", SRLW, 64'hFFFF_FFFF_8000_0000, 64'd4, 0, 0, 0, 0, 64'h134, 64'h0000_0000_0800_0000, 0, 64'h134));
        vecs.push_back(mk("sraw", SRAW, 64'h8000_0000, 64'd4, 0, 0, 0, 0, 64'h138, 64'hFFFF_FFFF_F800_0000, 0, 64'h138));
        vecs.push_back(mk("cmp_lts", CMP_LTS, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0, 0, 0, 0, 64'h13C, 64'd1, 0, 64'h13C));
        vecs.push_back(mk("cmp_ltu", CMP_LTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0, 0, 0, 0, 64'h140, 64'd0, 0, 64'h140));
        vecs.push_back(mk("cmp_eq", CMP_EQ, 64'd5, 64'd5, 0, 0, 0, 0, 64'h144, 64'd1, 0, 64'h144));
        vecs.push_back(mk("cmp_ne", CMP_NE, 64'd5, 64'd5, 0, 0, 0, 0, 64'h148, 64'd0, 0, 64'h148));
        vecs.push_back(mk("cmp_ges", CMP_GES, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0, 0, 0, 0, 64'h14C, 64'd0, 0, 64'h14C));
        vecs.push_back(mk("cmp_geu", CMP_GEU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0, 0, 0, 0, 64'h150, 64'd1, 0, 64'h150));
        vecs.push_back(mk("br_lts_taken_mp", CMP_LTS, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0, 1, 0, 64'h1000, 64'h804, 64'd0, 1, 64'h1000));
        vecs.push_back(mk("br_ltu_nt_ok", CMP_LTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0, 1, 0, 64'h1000, 64'h804, 64'd0, 0, 64'h804));
        vecs.push_back(mk("br_eq_taken_ok", CMP_EQ, 64'd3, 64'd3, 0, 1, 1, 64'h2000, 64'h900, 64'd0, 0, 64'h2000));
        vecs.push_back(mk("br_geu_nt_mp", CMP_GEU, 64'd1, 64'd2, 0, 1, 1, 64'h3000, 64'h904, 64'd0, 1, 64'h904));
        vecs.push_back(mk("jalr_ok", JAL_R, 64'h2001, 64'h10, 64'h404, 0, 1, 64'h2010, 64'h400, 64'h404, 0, 64'h2010));
        vecs.push_back(mk("jalr_bad_tgt", JAL_R, 64'h2001, 64'h10, 64'h404, 0, 1, 64'h2011, 64'h400, 64'h404, 1, 64'h2010));
        vecs.push_back(mk("jalr_not_pred", JAL_R, 64'h2001, 64'h10, 64'h404, 0, 0, 64'h2010, 64'h400, 64'h404, 1, 64'h2010));

        // ---------------- reset ----------------
        rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        drive_add(64'd0, 64'd0, '0);
        repeat (3) @(posedge clk_i);
        #1;
        check("reset out_valid", 64'(out_valid_o), 64'd0);
        check("reset in_ready", 64'(in_ready_o), 64'd1);
        check("reset result", out_result_o, 64'd0);
        check("reset trans_id", 64'(out_trans_id_o), 64'd0);
        check("reset mispredict", 64'(out_mispredict_o), 64'd0);
        check("reset redirect", out_redirect_pc_o, 64'd0);
        rst_i = 1'b0;

        foreach (vecs[i]) run_vector(vecs[i], TRANS_ID_W'(i));

        // ---------------- backpressure: 4 issues, out_ready low 3 cycles ----------------
        acc = 0; rcv = 0; stab_err = 0; seen_drop = 1'b0; stall_prev = 1'b0;
        prev_res = '0; prev_id = '0;
        for (int c = 0; c < 40 && rcv < 4; c++) begin
            @(posedge clk_i); #1;
            if (stall_prev && (!out_valid_o || out_result_o !== prev_res || out_trans_id_o !== prev_id))
                stab_err++;
            out_ready_i = (c >= 3);
            if (acc < 4) begin
                in_valid_i = 1'b1;
                drive_add(64'((acc + 1) * 256), 64'(acc), TRANS_ID_W'(acc + 2));
            end else begin
                in_valid_i = 1'b0;
            end
            #1;
            if (!seen_drop && !in_ready_o) begin
                seen_drop = 1'b1;
                check("bp accepted_before_stall", 64'(acc), 64'd2);
            end
            if (out_valid_o && out_ready_i) begin
                check("bp result", out_result_o, 64'((rcv + 1) * 256 + rcv));
                check("bp trans_id", 64'(out_trans_id_o), 64'(rcv + 2));
                rcv++;
            end
            stall_prev = out_valid_o && !out_ready_i;
            prev_res   = out_result_o;
            prev_id    = out_trans_id_o;
            if (in_valid_i && in_ready_o) acc++;
        end
        in_valid_i = 1'b0;
        check("bp ready_dropped", 64'(seen_drop), 64'd1);
        check("bp accepted", 64'(acc), 64'd4);
        check("bp received", 64'(rcv), 64'd4);
        check("bp stable_under_stall", 64'(stab_err), 64'd0);
        count_outputs(5, extra);
        check("bp no_duplicates", 64'(extra), 64'd0);

        // ---------------- flush with both stages full and issue offered ----------------
        @(posedge clk_i); #1;
        out_ready_i = 1'b0; in_valid_i = 1'b1; drive_add(64'h11, 64'h1, 3'd5);
        @(posedge clk_i); #1;
        drive_add(64'h22, 64'h2, 3'd6);
        @(posedge clk_i); #1;
        check("flush pre out_valid", 64'(out_valid_o), 64'd1);
        check("flush pre in_ready", 64'(in_ready_o), 64'd0);
        flush_i = 1'b1; drive_add(64'h33, 64'h3, 3'd7);
        @(posedge clk_i); #1;
        flush_i = 1'b0; in_valid_i = 1'b0;
        check("flush out_valid", 64'(out_valid_o), 64'd0);
        check("flush in_ready", 64'(in_ready_o), 64'd1);
        out_ready_i = 1'b1;
        count_outputs(6, extra);
        check("flush no_ghost_results", 64'(extra), 64'd0);

        // Flush on an empty unit with a new issue offered: the issue is dropped.
        in_valid_i = 1'b1; flush_i = 1'b1; drive_add(64'h44, 64'h4, 3'd1);
        @(posedge clk_i); #1;
        in_valid_i = 1'b0; flush_i = 1'b0;
        count_outputs(5, extra);
        check("flush drops_offered_issue", 64'(extra), 64'd0);

        run_vector(vecs[0], 3'd4);

        // ---------------- reset mid-operation ----------------
        @(posedge clk_i); #1;
        out_ready_i = 1'b0; in_valid_i = 1'b1; drive_add(64'h55, 64'h5, 3'd2);
        @(posedge clk_i); #1;
        drive_add(64'h66, 64'h6, 3'd3);
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        check("midrst pre result", out_result_o, 64'h5A);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        check("midrst out_valid", 64'(out_valid_o), 64'd0);
        check("midrst in_ready", 64'(in_ready_o), 64'd1);
        check("midrst result_cleared", out_result_o, 64'd0);
        check("midrst trans_id_cleared", 64'(out_trans_id_o), 64'd0);
        out_ready_i = 1'b1;
        count_outputs(5, k);
        check("midrst no_ghost_results", 64'(k), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
